// File: rtl/led_matrix_col_scan_if.sv
// ---------------------------------------------------------------------------
// led_matrix_col_scan_if
//
// Bundle between the frame/character generator (master) and the column
// scanner (slave).
//
//   enable      master->slave  1 = scan, 0 = display dark
//   frame_in    master->slave  frame, bit c*ROW_W+r = LED (col c, row r) on
//   load        master->slave  1-cycle strobe capturing frame_in
//   col_out     slave->master  column enables (at output polarity)
//   row_out     slave->master  row drive for the active column
//   col_idx     slave->master  index of the current column
//   frame_done  slave->master  1-cycle pulse at each full-scan wrap
//   busy        slave->master  1 whenever the scanner is not idle
//   state_dbg   slave->master  raw scanner state (0 idle, 1 blank, 2 show)
//
// Transfer semantics: there is no back-pressure. Every cycle with load=1
// is one accepted frame; the scanner always takes it (into the shadow at a
// frame boundary or scan start, otherwise into the pending buffer, where a
// later load simply overwrites it).
// ---------------------------------------------------------------------------
interface led_matrix_col_scan_if #(
    parameter int NUM_COLS = 5,
    parameter int ROW_W    = 7
);
    localparam int CIW = $clog2(NUM_COLS);

    logic                      enable;
    logic [NUM_COLS*ROW_W-1:0] frame_in;
    logic                      load;
    logic [NUM_COLS-1:0]       col_out;
    logic [ROW_W-1:0]          row_out;
    logic [CIW-1:0]            col_idx;
    logic                      frame_done;
    logic                      busy;
    logic [1:0]                state_dbg;

    modport master (
        output enable, frame_in, load,
        input  col_out, row_out, col_idx, frame_done, busy, state_dbg
    );

    modport slave (
        input  enable, frame_in, load,
        output col_out, row_out, col_idx, frame_done, busy, state_dbg
    );
endinterface

// File: rtl/led_matrix_col_scan.sv
// ---------------------------------------------------------------------------
// led_matrix_col_scan
//
// Time-multiplexed column scanner for an LED matrix. A full frame is
// double-buffered (pending -> shadow) and the columns are lit one at a time,
// each preceded by an optional all-off blank gap against ghosting.
//
// Ports:
//   clk    rising-edge system clock
//   reset  synchronous, active-high reset
//   bus    led_matrix_col_scan_if.slave (enable/frame_in/load in;
//          col_out/row_out/col_idx/frame_done/busy/state_dbg out)
//
// NUM_COLS and ROW_W must match the parameters of the connected interface.
// All outputs are registered from next-state values, so they change in the
// first cycle of each new state.
// ---------------------------------------------------------------------------
module led_matrix_col_scan #(
    parameter int NUM_COLS   = 5,
    parameter int ROW_W      = 7,
    parameter int DWELL_CYC  = 50000,
    parameter int BLANK_CYC  = 2,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    led_matrix_col_scan_if.slave  bus
);

    localparam int FW      = NUM_COLS * ROW_W;
    localparam int CIW     = $clog2(NUM_COLS);
    localparam int CNT_MAX = (DWELL_CYC > BLANK_CYC) ? DWELL_CYC : BLANK_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]    DWELL_LAST = CNT_W'(DWELL_CYC - 1);
    localparam logic [CNT_W-1:0]    BLANK_LAST = CNT_W'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
    localparam logic [CIW-1:0]      COL_LAST   = CIW'(NUM_COLS - 1);
    localparam bit                  HAS_BLANK  = (BLANK_CYC > 0);

    // Inactive levels; XOR with these converts logical on-values to pins.
    localparam logic [NUM_COLS-1:0] COL_OFF = {NUM_COLS{ACTIVE_LOW}};
    localparam logic [ROW_W-1:0]    ROW_OFF = {ROW_W{ACTIVE_LOW}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } state_t;

    state_t              state, state_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic [CIW-1:0]      col, col_n;
    logic [FW-1:0]       shadow, shadow_n;
    logic [FW-1:0]       pend, pend_n;
    logic                pvalid, pvalid_n;
    logic                fdone_n;
    logic                take;
    logic [NUM_COLS-1:0] col_hot_n;
    logic [ROW_W-1:0]    row_sel_n;

    logic [NUM_COLS-1:0] col_out_q;
    logic [ROW_W-1:0]    row_out_q;
    logic                frame_done_q;
    logic                busy_q;

    // -----------------------------------------------------------------------
    // Next-state, counters and buffer update
    // -----------------------------------------------------------------------
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        col_n    = col;
        shadow_n = shadow;
        pend_n   = pend;
        pvalid_n = pvalid;
        fdone_n  = 1'b0;
        take     = 1'b0;

        case (state)
            ST_IDLE: begin
                if (bus.enable) begin
                    state_n = HAS_BLANK ? ST_BLANK : ST_SHOW;
                    cnt_n   = '0;
                    col_n   = '0;
                    // Scan start refreshes the shadow so the first frame
                    // shows the latest data.
                    take    = 1'b1;
                end
            end

            ST_BLANK: begin
                if (cnt == BLANK_LAST) begin
                    state_n = ST_SHOW;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end

            ST_SHOW: begin
                if (cnt == DWELL_LAST) begin
                    state_n = HAS_BLANK ? ST_BLANK : ST_SHOW;
                    cnt_n   = '0;
                    if (col == COL_LAST) begin
                        // Frame boundary: wrap, pulse, swap buffers.
                        col_n   = '0;
                        fdone_n = 1'b1;
                        take    = 1'b1;
                    end else begin
                        col_n = col + 1'b1;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end

            default: begin
                state_n = ST_IDLE;
                cnt_n   = '0;
                col_n   = '0;
            end
        endcase

        // Disable wins over everything above; buffers are kept.
        if (!bus.enable) begin
            state_n = ST_IDLE;
            cnt_n   = '0;
            col_n   = '0;
            fdone_n = 1'b0;
            take    = 1'b0;
        end

        if (take) begin
            // A load in the swap cycle bypasses the pending buffer.
            if (bus.load) begin
                shadow_n = bus.frame_in;
            end else if (pvalid) begin
                shadow_n = pend;
            end
            pvalid_n = 1'b0;
        end else if (bus.load) begin
            pend_n   = bus.frame_in;
            pvalid_n = 1'b1;
        end
    end

    // Logical (active-high) drive for the column/rows of the next state.
    always_comb begin
        col_hot_n = NUM_COLS'(1) << col_n;
        row_sel_n = shadow_n[int'(col_n) * ROW_W +: ROW_W];
    end

    // -----------------------------------------------------------------------
    // State and output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            col          <= '0;
            shadow       <= '0;
            pend         <= '0;
            pvalid       <= 1'b0;
            col_out_q    <= COL_OFF;
            row_out_q    <= ROW_OFF;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            col          <= col_n;
            shadow       <= shadow_n;
            pend         <= pend_n;
            pvalid       <= pvalid_n;
            col_out_q    <= (state_n == ST_SHOW) ? (col_hot_n ^ COL_OFF) : COL_OFF;
            row_out_q    <= (state_n == ST_SHOW) ? (row_sel_n ^ ROW_OFF) : ROW_OFF;
            frame_done_q <= fdone_n;
            busy_q       <= (state_n != ST_IDLE);
        end
    end

    assign bus.col_out    = col_out_q;
    assign bus.row_out    = row_out_q;
    assign bus.col_idx    = col;
    assign bus.frame_done = frame_done_q;
    assign bus.busy       = busy_q;
    assign bus.state_dbg  = state;

endmodule

// File: tb/tb_led_matrix_col_scan.sv
// ---------------------------------------------------------------------------
// tb_led_matrix_col_scan
//
// Directed scenarios followed by random enable/load/reset traffic. Expected
// outputs come from a frame-time model: position in the scan is derived from
// the number of cycles since scan start, and the buffers are updated at the
// frame-period multiples.
// ---------------------------------------------------------------------------
module tb_led_matrix_col_scan;

    localparam int NC     = 5;
    localparam int RW     = 7;
    localparam int DW     = 4;
    localparam int BK     = 1;
    localparam bit AL     = 1'b1;
    localparam int FW     = NC * RW;
    localparam int SLOT   = BK + DW;
    localparam int PERIOD = NC * SLOT;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    led_matrix_col_scan_if #(.NUM_COLS(NC), .ROW_W(RW)) bus ();

    led_matrix_col_scan #(
        .NUM_COLS  (NC),
        .ROW_W     (RW),
        .DWELL_CYC (DW),
        .BLANK_CYC (BK),
        .ACTIVE_LOW(AL)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // ---------------- scoreboard counters ----------------
    int n_cmp  = 0;
    int n_fail = 0;

    // ---------------- reference model state ----------------
    bit            m_on;
    int            m_t;
    logic [FW-1:0] m_shadow;
    logic [FW-1:0] m_pend;
    bit            m_pv;
    bit            m_fd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [FW-1:0] rand_frame();
        return FW'({$urandom(), $urandom()});
    endfunction

    // Apply one clock edge worth of inputs to the model.
    task automatic model_edge(input bit rst_i, input bit en_i, input bit ld_i,
                              input logic [FW-1:0] fr_i);
        bit take;
        take = 1'b0;
        m_fd = 1'b0;
        if (rst_i) begin
            m_on = 1'b0; m_t = 0; m_shadow = '0; m_pend = '0; m_pv = 1'b0;
        end else if (!en_i) begin
            m_on = 1'b0; m_t = 0;
            if (ld_i) begin m_pend = fr_i; m_pv = 1'b1; end
        end else begin
            if (!m_on) begin
                m_on = 1'b1; m_t = 0; take = 1'b1;
            end else begin
                m_t++;
                if (m_t % PERIOD == 0) begin take = 1'b1; m_fd = 1'b1; end
            end
            if (take) begin
                if (ld_i) m_shadow = fr_i;
                else if (m_pv) m_shadow = m_pend;
                m_pv = 1'b0;
            end else if (ld_i) begin
                m_pend = fr_i; m_pv = 1'b1;
            end
        end
    endtask

    task automatic compare_all();
        int ph, c, w;
        logic [NC-1:0] e_col;
        logic [RW-1:0] e_row;
        int e_idx;
        bit e_busy;
        e_col = '0; e_row = '0; e_idx = 0; e_busy = 1'b0;
        if (m_on) begin
            ph = m_t % PERIOD;
            c  = ph / SLOT;
            w  = ph % SLOT;
            e_idx  = c;
            e_busy = 1'b1;
            if (w >= BK) begin
                e_col = NC'(1) << c;
                e_row = m_shadow[c*RW +: RW];
            end
        end
        if (AL) begin e_col = ~e_col; e_row = ~e_row; end
        chk("col_out",    32'(bus.col_out),    32'(e_col));
        chk("row_out",    32'(bus.row_out),    32'(e_row));
        chk("col_idx",    32'(bus.col_idx),    32'(e_idx));
        chk("frame_done", 32'(bus.frame_done), 32'(m_fd));
        chk("busy",       32'(bus.busy),       32'(e_busy));
    endtask

    // ---------------- driver ----------------
    task automatic tick(input bit rst_i, input bit en_i, input bit ld_i,
                        input logic [FW-1:0] fr_i);
        reset        = rst_i;
        bus.enable   = en_i;
        bus.load     = ld_i;
        bus.frame_in = fr_i;
        @(posedge clk);
        #1;
        model_edge(rst_i, en_i, ld_i, fr_i);
        compare_all();
    endtask

    // Run enabled, no loads, until the model sits at frame phase ph.
    task automatic advance_to(input int ph);
        for (int k = 0; k < 2 * PERIOD && (m_t % PERIOD) != ph; k++)
            tick(1'b0, 1'b1, 1'b0, '0);
    endtask

    // ---------------- stimulus ----------------
    logic [FW-1:0] f1, f55;
    int            fd_seen, bad_rows, off_left;
    bit            en_r, ld_r, rst_r;

    initial begin
        reset = 1'b1; bus.enable = 1'b0; bus.load = 1'b0; bus.frame_in = '0;
        m_on = 1'b0; m_t = 0; m_shadow = '0; m_pend = '0; m_pv = 1'b0; m_fd = 1'b0;

        // 1. reset, then idle
        tick(1'b1, 1'b0, 1'b0, '0);
        tick(1'b1, 1'b0, 1'b0, '0);
        tick(1'b0, 1'b0, 1'b0, '0);
        chk("idle_col_out", 32'(bus.col_out), 32'h1F);
        chk("idle_row_out", 32'(bus.row_out), 32'h7F);
        chk("idle_busy",    32'(bus.busy),    32'h0);

        // 2. diagonal frame, then scan two frames
        f1 = {7'h10, 7'h08, 7'h04, 7'h02, 7'h01};
        tick(1'b0, 1'b0, 1'b1, f1);
        tick(1'b0, 1'b1, 1'b0, '0);
        chk("start_blank_col", 32'(bus.col_out), 32'h1F);
        tick(1'b0, 1'b1, 1'b0, '0);
        chk("col0_show_col", 32'(bus.col_out), 32'h1E);
        chk("col0_show_row", 32'(bus.row_out), 32'h7E);
        fd_seen = 0;
        for (int i = 0; i < 2 * PERIOD - 1; i++) begin
            tick(1'b0, 1'b1, 1'b0, '0);
            if (bus.frame_done) fd_seen++;
        end
        chk("frame_done_count", 32'(fd_seen), 32'd2);

        // 3. mid-frame load of all ones during column 2
        advance_to(11);
        tick(1'b0, 1'b1, 1'b1, {FW{1'b1}});
        advance_to(1);
        chk("after_wrap_all_on", 32'(bus.row_out), 32'h00);

        // 4. load exactly in the boundary cycle (bypass)
        f55 = rand_frame();
        f55[RW-1:0] = 7'h55;
        advance_to(PERIOD - 1);
        tick(1'b0, 1'b1, 1'b1, f55);
        chk("bypass_fd", 32'(bus.frame_done), 32'h1);
        tick(1'b0, 1'b1, 1'b0, '0);
        chk("bypass_row", 32'(bus.row_out), 32'h2A);

        // 5. drop enable during column 3 show, then restart
        advance_to(3 * SLOT + 1);
        tick(1'b0, 1'b0, 1'b0, '0);
        chk("drop_busy", 32'(bus.busy), 32'h0);
        chk("drop_col",  32'(bus.col_out), 32'h1F);
        tick(1'b0, 1'b0, 1'b0, '0);
        tick(1'b0, 1'b1, 1'b0, '0);
        chk("restart_idx", 32'(bus.col_idx), 32'h0);
        tick(1'b0, 1'b1, 1'b0, '0);
        chk("restart_col", 32'(bus.col_out), 32'h1E);
        chk("restart_row", 32'(bus.row_out), 32'h2A);

        // 6. reset during column 1 show with a pending frame
        advance_to(3);
        tick(1'b0, 1'b1, 1'b1, rand_frame() | FW'(1));
        advance_to(SLOT + 1);
        tick(1'b1, 1'b1, 1'b0, '0);
        chk("rst_mid_busy", 32'(bus.busy), 32'h0);
        tick(1'b0, 1'b1, 1'b0, '0);
        bad_rows = 0;
        for (int i = 0; i < PERIOD; i++) begin
            tick(1'b0, 1'b1, 1'b0, '0);
            if (bus.row_out !== 7'h7F) bad_rows++;
        end
        chk("cleared_rows", 32'(bad_rows), 32'd0);

        // 7. random traffic
        off_left = 0;
        for (int i = 0; i < 1500; i++) begin
            rst_r = ($urandom_range(0, 399) == 0);
            if (off_left == 0 && $urandom_range(0, 99) == 0)
                off_left = $urandom_range(1, 6);
            en_r = (off_left == 0);
            if (off_left > 0) off_left--;
            ld_r = ($urandom_range(0, 9) == 0);
            tick(rst_r, en_r, ld_r, rand_frame());
        end

        // ---------------- report ----------------
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/led_matrix_col_scan.md
Name: led_matrix_col_scan

Overview:
- Time-multiplexed column scanner for the LED matrix display.
- Takes a full frame (one row pattern per column), double-buffers it, and cycles through the columns one at a time: drives one column enable and that column's row pattern, with programmable dwell time and an anti-ghosting blank gap.
- Sits between the frame/character generator and the matrix pins, replacing static per-column decoding with a clocked scan.

Parameters:
- NUM_COLS, 5, number of matrix columns; 2..16.
- ROW_W, 7, rows per column; 1..16.
- DWELL_CYC, 50000, clock cycles each column is lit; >=1.
- BLANK_CYC, 2, all-off cycles before each column is lit; 0 disables blanking.
- ACTIVE_LOW, 1, 1 = column and row outputs active-low; 0 = active-high.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  1 = scan; 0 = display dark.
- frame_in  in  NUM_COLS*ROW_W  new frame; bit c*ROW_W+r = 1 means LED (col c, row r) on.
- load  in  1  1-cycle strobe that captures frame_in into the pending buffer.
- col_out  out  NUM_COLS  column enables; at most one active.
- row_out  out  ROW_W  row drive for the active column.
- col_idx  out  clog2(NUM_COLS)  index of the current column.
- frame_done  out  1  1-cycle pulse at the end of each full scan.
- busy  out  1  1 whenever the state is not IDLE.

Behaviour:
- Reset values:
  - State IDLE.
  - col_out and row_out all at the inactive level (all 1 if ACTIVE_LOW, else all 0).
  - col_idx=0, frame_done=0, busy=0.
  - Shadow frame=0, pending buffer=0, pend_valid=0.
- All outputs are registered and show the current state: an output takes its new value in the first cycle of a new state.
- Polarity: when ACTIVE_LOW=1, each col_out/row_out bit is the inverse of its logical on-value.
- States:
  - IDLE: outputs inactive, col_idx=0. When enable=1, the next cycle enters BLANK (or SHOW if BLANK_CYC=0) with column 0.
  - BLANK: lasts exactly BLANK_CYC cycles. col_out and row_out are inactive; col_idx already shows the upcoming column. Then go to SHOW.
  - SHOW: lasts exactly DWELL_CYC cycles.
    - col_out has only bit col_idx active.
    - row_out = shadow[col_idx*ROW_W +: ROW_W] at the output polarity.
    - After the last cycle: col_idx increments and the state goes to BLANK, or to SHOW if BLANK_CYC=0.
- Wrap and frame boundary (leaving SHOW of column NUM_COLS-1):
  - col_idx wraps to 0.
  - frame_done=1 for exactly one cycle: the first cycle of column 0's BLANK/SHOW.
  - Shadow update, decided in the same cycle:
    - load=1 that cycle: shadow<=frame_in (bypass).
    - Otherwise, pend_valid=1: shadow<=pending.
    - Then pend_valid<=0.
- Load behaviour:
  - load=1 off the boundary: pending<=frame_in and pend_valid<=1.
  - Shadow never changes mid-frame, so there is no tearing.
  - A later load overwrites pending; the last one before the boundary wins.
- Shadow first load:
  - The first boundary after reset with pend_valid=1 loads the shadow.
  - While leaving IDLE, the shadow is also updated from pending or load, so the first scanned frame shows the latest data.
- enable=0 in any state: the next cycle is IDLE, all outputs are inactive, and the counters clear.
  - pending and pend_valid are kept; shadow is kept.
  - No frame_done is issued.
- Re-enable always restarts at column 0.
- reset=1 in any state: on that clock edge, every register returns to its reset value; reset overrides enable and load.
- Dwell counter: width clog2(max(DWELL_CYC,BLANK_CYC)+1), counts 0..N-1, no overflow.
- Column scan period = NUM_COLS*(BLANK_CYC+DWELL_CYC) cycles.

Test Plan (NUM_COLS=5, ROW_W=7, DWELL_CYC=4, BLANK_CYC=1, ACTIVE_LOW=1):
1. Reset for 2 cycles, then enable=0 -> col_out=5'b11111, row_out=7'b1111111, col_idx=0, busy=0, frame_done=0.
2. load frame_in with col0=7'h01, col1=7'h02, col2=7'h04, col3=7'h08, col4=7'h10; enable=1.
   - Per column: 1 cycle with col_out=11111, then 4 cycles with col_out=11110 and row_out=1111110 (column 0).
   - Pattern repeats for columns 1..4.
   - frame_done pulses once every 25 cycles.
3. Mid-frame load of all-ones (35'h7FFFFFFFF) during column 2 -> columns 2..4 keep the old data; after wrap, column 0 shows row_out=0000000.
4. load=1 in exactly the boundary cycle with frame_in col0=7'h55 -> column 0 of the next frame shows row_out=~7'h55=7'h2A (bypass).
5. enable dropped during column 3 SHOW -> next cycle IDLE with all outputs inactive; re-enable -> restarts with BLANK on column 0 and shows the old shadow data.
6. reset asserted during column 1 SHOW while pend_valid=1 -> next cycle all outputs at reset values and pend_valid=0; after enable, row_out=1111111 in every column (shadow cleared).
